pc_sequencer: RTL and testbench

Parametrised program-counter sequencer for the 12-bit microcontroller fetch stage, superseding the fixed 8-bit combinational incrementer. It holds the program counter and selects the next address each cycle: increment, skip, absolute jump, subroutine call or return. Calls and returns use an internal return-address stack of configurable depth. The instruction decoder drives the op code, and `pc` addresses program memory directly.

---
 rtl/pc_sequencer_if.sv | 24 ++
 rtl/pc_sequencer.sv | 107 ++++++++++
 tb/tb_pc_sequencer.sv | 202 ++++++++++++++++++++
 3 files changed

// File: rtl/pc_sequencer_if.sv
// Fetch-stage bus between the instruction decoder (master) and the program-counter
// sequencer (slave).
interface pc_sequencer_if #(
    parameter int ADDR_W = 8
);
    logic              en;
    logic [2:0]        op;
    logic [ADDR_W-1:0] target;
    logic [ADDR_W-1:0] pc;
    logic              stack_empty;
    logic              stack_full;
    logic              ovf_err;
    logic              unf_err;

    modport master (
        output en, op, target,
        input  pc, stack_empty, stack_full, ovf_err, unf_err
    );

    modport slave (
        input  en, op, target,
        output pc, stack_empty, stack_full, ovf_err, unf_err
    );
endinterface

// File: rtl/pc_sequencer.sv
// Program-counter sequencer: increment, skip, jump, call and return, with a
// return-address LIFO and sticky overflow/underflow flags.
module pc_sequencer #(
    parameter int                ADDR_W      = 8,
    parameter int                STACK_DEPTH = 4,
    parameter logic [ADDR_W-1:0] RESET_VEC   = '0
) (
    input logic           clk,
    input logic           rst,
    pc_sequencer_if.slave bus
);
    localparam int SP_W  = $clog2(STACK_DEPTH + 1);
    localparam int IDX_W = (STACK_DEPTH > 1) ? $clog2(STACK_DEPTH) : 1;

    typedef enum logic [2:0] {
        OP_HOLD = 3'b000,
        OP_INC  = 3'b001,
        OP_SKIP = 3'b010,
        OP_JUMP = 3'b011,
        OP_CALL = 3'b100,
        OP_RET  = 3'b101
    } op_e;

    logic [ADDR_W-1:0] pc_q, pc_d;
    logic [SP_W-1:0]   sp_q, sp_d;
    logic              ovf_q, ovf_d;
    logic              unf_q, unf_d;
    logic              push;
    logic [ADDR_W-1:0] stack_q [STACK_DEPTH];

    logic [ADDR_W-1:0] pc_inc1, pc_inc2;
    logic [IDX_W-1:0]  push_idx, pop_idx;
    logic              empty, full;
    op_e               op;

    assign op       = op_e'(bus.op);
    assign pc_inc1  = pc_q + ADDR_W'(1);
    assign pc_inc2  = pc_q + ADDR_W'(2);
    assign empty    = (sp_q == '0);
    assign full     = (sp_q == SP_W'(STACK_DEPTH));
    assign push_idx = IDX_W'(sp_q);
    assign pop_idx  = IDX_W'(sp_q - SP_W'(1));

    always_comb begin
        // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
        pc_d  = pc_q;
        sp_d  = sp_q;
        ovf_d = ovf_q;
        unf_d = unf_q;
        push  = 1'b0;
        if (bus.en) begin
            case (op)
                OP_INC:  pc_d = pc_inc1;
                OP_SKIP: pc_d = pc_inc2;
                OP_JUMP: pc_d = bus.target;
                OP_CALL: begin
                    // A call into a full stack is dropped and execution falls through.
                    if (full) begin
                        ovf_d = 1'b1;
                        pc_d  = pc_inc1;
                    end else begin
                        push = 1'b1;
                        sp_d = sp_q + SP_W'(1);
                        pc_d = bus.target;
                    end
                end
                OP_RET: begin
                    if (empty) begin
                        unf_d = 1'b1;
                        pc_d  = pc_inc1;
                    end else begin
                        sp_d = sp_q - SP_W'(1);
                        pc_d = stack_q[pop_idx];
                    end
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            pc_q  <= RESET_VEC;
            sp_q  <= '0;
            ovf_q <= 1'b0;
            unf_q <= 1'b0;
        end else begin
            pc_q  <= pc_d;
            sp_q  <= sp_d;
            ovf_q <= ovf_d;
            unf_q <= unf_d;
        end
    end

    // NOTE: stack entries are not reset; sp=0 makes stale contents unreachable.
    always_ff @(posedge clk) begin
        if (push) begin
            stack_q[push_idx] <= pc_inc1;
        end
    end

    assign bus.pc          = pc_q;
    assign bus.stack_empty = empty;
    assign bus.stack_full  = full;
    assign bus.ovf_err     = ovf_q;
    assign bus.unf_err     = unf_q;
endmodule

// File: tb/tb_pc_sequencer.sv
// Self-checking bench for pc_sequencer: directed vector table, a hand-written
// call/stall/return sequence, and random ops against a queue-based reference model.
module tb_pc_sequencer;
    localparam int         ADDR_W      = 8;
    localparam int         STACK_DEPTH = 4;
    localparam logic [7:0] RV          = 8'h10;

    localparam logic [2:0] HOLD = 3'd0, INC = 3'd1, SKIP = 3'd2, JUMP = 3'd3,
                           CALL = 3'd4, RET = 3'd5, RSV6 = 3'd6, RSV7 = 3'd7;

    typedef struct {
        logic       rst;
        logic       en;
        logic [2:0] op;
        logic [7:0] tgt;
        logic [7:0] pc;
        logic       empty;
        logic       full;
        logic       ovf;
        logic       unf;
    } vec_t;

    logic clk = 1'b0;
    logic rst = 1'b0;
    int   n_checks = 0;
    int   n_fail   = 0;
    vec_t vecs[$];

    // Reference model state
    int m_pc;
    int m_stack[$];
    bit m_ovf, m_unf;

    pc_sequencer_if #(.ADDR_W(ADDR_W)) bus ();

    pc_sequencer #(
        .ADDR_W     (ADDR_W),
        .STACK_DEPTH(STACK_DEPTH),
        .RESET_VEC  (RV)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] actual, input logic [31:0] expected);
        n_checks++;
        if (actual !== expected) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, actual, expected, $time);
        end
    endtask

    task automatic add_vec(input logic r, input logic e, input logic [2:0] o, input logic [7:0] t,
                           input logic [7:0] p, input logic emp, input logic ful,
                           input logic ov, input logic un);
        vec_t v;
        v.rst = r; v.en = e; v.op = o; v.tgt = t;
        v.pc = p; v.empty = emp; v.full = ful; v.ovf = ov; v.unf = un;
        vecs.push_back(v);
    endtask

    // Drive one cycle, then sample 1 time unit after the rising edge.
    task automatic step(input logic r, input logic e, input logic [2:0] o, input logic [7:0] t);
        rst        = r;
        bus.en     = e;
        bus.op     = o;
        bus.target = t;
        @(posedge clk);
        #1;
    endtask

    task automatic check_all(input string tag, input logic [7:0] p, input logic emp,
                             input logic ful, input logic ov, input logic un);
        check({tag, ".pc"},    32'(bus.pc),          32'(p));
        check({tag, ".empty"}, 32'(bus.stack_empty), 32'(emp));
        check({tag, ".full"},  32'(bus.stack_full),  32'(ful));
        check({tag, ".ovf"},   32'(bus.ovf_err),     32'(ov));
        check({tag, ".unf"},   32'(bus.unf_err),     32'(un));
    endtask

    task automatic model_step(input bit r, input bit e, input int o, input int t);
        if (r) begin
            m_pc = RV;
            m_stack.delete();
            m_ovf = 0;
            m_unf = 0;
        end else if (e) begin
            case (o)
                1: m_pc = (m_pc + 1) % 256;
                2: m_pc = (m_pc + 2) % 256;
                3: m_pc = t;
                4: if (m_stack.size() == STACK_DEPTH) begin
                       m_ovf = 1;
                       m_pc  = (m_pc + 1) % 256;
                   end else begin
                       m_stack.push_back((m_pc + 1) % 256);
                       m_pc = t;
                   end
                5: if (m_stack.size() == 0) begin
                       m_unf = 1;
                       m_pc  = (m_pc + 1) % 256;
                   end else begin
                       m_pc = m_stack.pop_back();
                   end
                default: ;
            endcase
        end
    endtask

    initial begin
        rst = 1'b0; bus.en = 1'b0; bus.op = HOLD; bus.target = '0;

        // rst, en, op, target  ->  pc, empty, full, ovf, unf
        add_vec(1, 1, INC,  8'h00, 8'h10, 1, 0, 0, 0);
        add_vec(0, 1, INC,  8'h00, 8'h11, 1, 0, 0, 0);
        add_vec(0, 1, INC,  8'h00, 8'h12, 1, 0, 0, 0);
        add_vec(0, 1, INC,  8'h00, 8'h13, 1, 0, 0, 0);
        add_vec(0, 1, HOLD, 8'h55, 8'h13, 1, 0, 0, 0);
        add_vec(0, 1, RSV6, 8'h55, 8'h13, 1, 0, 0, 0);
        add_vec(0, 1, RSV7, 8'h55, 8'h13, 1, 0, 0, 0);
        add_vec(0, 1, JUMP, 8'hFE, 8'hFE, 1, 0, 0, 0);
        add_vec(0, 1, INC,  8'h00, 8'hFF, 1, 0, 0, 0);
        add_vec(0, 1, INC,  8'h00, 8'h00, 1, 0, 0, 0);
        add_vec(0, 1, SKIP, 8'h00, 8'h02, 1, 0, 0, 0);
        add_vec(0, 1, JUMP, 8'hFF, 8'hFF, 1, 0, 0, 0);
        add_vec(0, 1, SKIP, 8'h00, 8'h01, 1, 0, 0, 0);
        add_vec(0, 1, JUMP, 8'hFE, 8'hFE, 1, 0, 0, 0);
        add_vec(0, 1, SKIP, 8'h00, 8'h00, 1, 0, 0, 0);
        // Nested calls
        add_vec(0, 1, JUMP, 8'h20, 8'h20, 1, 0, 0, 0);
        add_vec(0, 1, CALL, 8'h40, 8'h40, 0, 0, 0, 0);
        add_vec(0, 1, CALL, 8'h60, 8'h60, 0, 0, 0, 0);
        add_vec(0, 1, RET,  8'h00, 8'h41, 0, 0, 0, 0);
        add_vec(0, 1, RET,  8'h00, 8'h21, 1, 0, 0, 0);
        // CALL at all-ones pushes 0
        add_vec(0, 1, JUMP, 8'hFF, 8'hFF, 1, 0, 0, 0);
        add_vec(0, 1, CALL, 8'h33, 8'h33, 0, 0, 0, 0);
        add_vec(0, 1, RET,  8'h00, 8'h00, 1, 0, 0, 0);
        // Overflow
        add_vec(0, 1, JUMP, 8'h00, 8'h00, 1, 0, 0, 0);
        add_vec(0, 1, CALL, 8'h10, 8'h10, 0, 0, 0, 0);
        add_vec(0, 1, CALL, 8'h20, 8'h20, 0, 0, 0, 0);
        add_vec(0, 1, CALL, 8'h30, 8'h30, 0, 0, 0, 0);
        add_vec(0, 1, CALL, 8'h40, 8'h40, 0, 1, 0, 0);
        add_vec(0, 1, CALL, 8'h50, 8'h41, 0, 1, 1, 0);
        add_vec(0, 1, RET,  8'h00, 8'h31, 0, 0, 1, 0);
        add_vec(0, 1, RET,  8'h00, 8'h21, 0, 0, 1, 0);
        add_vec(0, 1, RET,  8'h00, 8'h11, 0, 0, 1, 0);
        add_vec(0, 1, RET,  8'h00, 8'h01, 1, 0, 1, 0);
        // Underflow and stall
        add_vec(0, 1, JUMP, 8'h05, 8'h05, 1, 0, 1, 0);
        add_vec(0, 1, RET,  8'h00, 8'h06, 1, 0, 1, 1);
        add_vec(0, 0, JUMP, 8'h99, 8'h06, 1, 0, 1, 1);
        add_vec(0, 0, JUMP, 8'h99, 8'h06, 1, 0, 1, 1);
        add_vec(0, 1, INC,  8'h00, 8'h07, 1, 0, 1, 1);
        // Reset mid-chain; reset also overrides en=0
        add_vec(1, 0, JUMP, 8'h77, 8'h10, 1, 0, 0, 0);
        add_vec(0, 1, CALL, 8'h30, 8'h30, 0, 0, 0, 0);
        add_vec(0, 1, CALL, 8'h50, 8'h50, 0, 0, 0, 0);
        add_vec(1, 1, CALL, 8'h70, 8'h10, 1, 0, 0, 0);
        add_vec(0, 1, RET,  8'h00, 8'h11, 1, 0, 0, 1);

        for (int i = 0; i < vecs.size(); i++) begin
            step(vecs[i].rst, vecs[i].en, vecs[i].op, vecs[i].tgt);
            check_all($sformatf("vec%0d", i), vecs[i].pc, vecs[i].empty,
                      vecs[i].full, vecs[i].ovf, vecs[i].unf);
        end

        // Back-to-back CALL/RET, then CALL, stall, RET
        step(1, 1, HOLD, 8'h00);
        step(0, 1, CALL, 8'h80);
        step(0, 1, RET,  8'h00);
        check_all("b2b_ret", 8'h11, 1, 0, 0, 0);
        step(0, 1, CALL, 8'hC0);
        step(0, 0, RET,  8'h00);
        check_all("stall_hold", 8'hC0, 0, 0, 0, 0);
        step(0, 1, RET,  8'h00);
        check_all("stall_ret", 8'h12, 1, 0, 0, 0);

        // Random ops against the reference model
        model_step(1, 1, 0, 0);
        step(1, 1, HOLD, 8'h00);
        for (int i = 0; i < 600; i++) begin
            bit r, e;
            int o, t;
            r = ($urandom_range(0, 39) == 0);
            e = ($urandom_range(0, 3) != 0);
            o = $urandom_range(0, 7);
            t = $urandom_range(0, 255);
            model_step(r, e, o, t);
            step(r, e, 3'(o), 8'(t));
            check_all($sformatf("rnd%0d", i), 8'(m_pc), m_stack.size() == 0,
                      m_stack.size() == STACK_DEPTH, m_ovf, m_unf);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
